// File: rtl/ysyx_24100006_wbu.sv
// Write-back stage: latches one retired instruction, then on the following edge
// commits GPR/CSR/PC updates and emits a one-cycle commit pulse with the next PC.
module ysyx_24100006_wbu #(
  parameter logic [31:0] RESET_PC     = 32'h8000_0000,
  parameter int          NR_GPR       = 16,
  parameter logic [31:0] MCAUSE_ECALL = 32'd11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc_W,
  input  logic [31:0] alu_result_W,
  input  logic [31:0] sext_imm_W,
  input  logic [31:0] rs1_data_W,
  input  logic [31:0] rdata_csr_W,
  input  logic [31:0] Mem_rdata_extend,
  input  logic [3:0]  rd_addr_W,
  input  logic [11:0] csr_addr_W,
  input  logic        irq_W,
  input  logic        mret_W,
  input  logic        PCW_W,
  input  logic        Gpr_Write_W,
  input  logic [2:0]  Gpr_Write_RD_W,
  input  logic        Csr_Write_W,
  input  logic [1:0]  Csr_Write_RD_W,
  input  logic [3:0]  raddr1,
  input  logic [3:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic [31:0] pc,
  output logic        commit_valid,
  output logic [31:0] npc
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t      state_r, state_nx_s;
  logic        accept_s;

  logic [31:0] beat_pc_r, beat_alu_r, beat_imm_r, beat_rs1_r, beat_csr_old_r, beat_mem_r;
  logic [3:0]  beat_rd_r;
  logic [11:0] beat_csr_addr_r;
  logic        beat_irq_r, beat_mret_r, beat_pcw_r, beat_gpr_we_r, beat_csr_we_r;
  logic [2:0]  beat_gpr_sel_r;
  logic [1:0]  beat_csr_op_r;

  logic [31:0] gpr_r [NR_GPR];
  logic [31:0] mstatus_r, mtvec_r, mepc_r, mcause_r;
  logic [31:0] pc_r, npc_r;
  logic        commit_r;

  logic [31:0] pc_plus4_s, gpr_wdata_s, csr_wdata_s, next_pc_s;
  logic        gpr_we_s, csr_we_s;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx_s = WRITE;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WRITE:   state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  assign in_ready = (state_r == IDLE);

  // Capture of the accepted beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_pc_r       <= 32'd0;
      beat_alu_r      <= 32'd0;
      beat_imm_r      <= 32'd0;
      beat_rs1_r      <= 32'd0;
      beat_csr_old_r  <= 32'd0;
      beat_mem_r      <= 32'd0;
      beat_rd_r       <= 4'd0;
      beat_csr_addr_r <= 12'd0;
      beat_irq_r      <= 1'b0;
      beat_mret_r     <= 1'b0;
      beat_pcw_r      <= 1'b0;
      beat_gpr_we_r   <= 1'b0;
      beat_gpr_sel_r  <= 3'd0;
      beat_csr_we_r   <= 1'b0;
      beat_csr_op_r   <= 2'd0;
    end else if (accept_s) begin
      beat_pc_r       <= pc_W;
      beat_alu_r      <= alu_result_W;
      beat_imm_r      <= sext_imm_W;
      beat_rs1_r      <= rs1_data_W;
      beat_csr_old_r  <= rdata_csr_W;
      beat_mem_r      <= Mem_rdata_extend;
      beat_rd_r       <= rd_addr_W;
      beat_csr_addr_r <= csr_addr_W;
      beat_irq_r      <= irq_W;
      beat_mret_r     <= mret_W;
      beat_pcw_r      <= PCW_W;
      beat_gpr_we_r   <= Gpr_Write_W;
      beat_gpr_sel_r  <= Gpr_Write_RD_W;
      beat_csr_we_r   <= Csr_Write_W;
      beat_csr_op_r   <= Csr_Write_RD_W;
    end else begin
      beat_pc_r <= beat_pc_r;
    end
  end

  // Write-back source, CSR operation and next-PC selection
  always_comb begin
    pc_plus4_s  = beat_pc_r + 32'd4;
    gpr_wdata_s = 32'd0;
    csr_wdata_s = 32'd0;
    next_pc_s   = pc_plus4_s;
    case (beat_gpr_sel_r)
      3'b000:  gpr_wdata_s = beat_alu_r;
      3'b001:  gpr_wdata_s = beat_mem_r;
      3'b010:  gpr_wdata_s = pc_plus4_s;
      3'b011:  gpr_wdata_s = beat_imm_r;
      3'b100:  gpr_wdata_s = beat_csr_old_r;
      default: gpr_wdata_s = 32'd0;
    endcase
    case (beat_csr_op_r)
      2'b00:   csr_wdata_s = beat_rs1_r;
      2'b01:   csr_wdata_s = beat_csr_old_r | beat_rs1_r;
      2'b10:   csr_wdata_s = beat_csr_old_r & ~beat_rs1_r;
      default: csr_wdata_s = 32'd0;
    endcase
    // Trap vector and return address use the CSR values from before this beat
    if (beat_irq_r) begin
      next_pc_s = mtvec_r;
    end else if (beat_mret_r) begin
      next_pc_s = mepc_r;
    end else if (beat_pcw_r) begin
      next_pc_s = beat_alu_r;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  assign gpr_we_s = (state_r == WRITE) && beat_gpr_we_r && (beat_rd_r != 4'd0);
  assign csr_we_s = (state_r == WRITE) && beat_csr_we_r && (beat_csr_op_r != 2'b11);

  // GPR file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_GPR; i++) begin
        gpr_r[i] <= 32'd0;
      end
    end else if (gpr_we_s) begin
      gpr_r[beat_rd_r] <= gpr_wdata_s;
    end else begin
      gpr_r[0] <= 32'd0;
    end
  end

  // Machine CSRs; the trap update is placed last so it wins over a same-beat write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_r <= 32'h0000_1800;
      mtvec_r   <= 32'd0;
      mepc_r    <= 32'd0;
      mcause_r  <= 32'd0;
    end else if (state_r == WRITE) begin
      if (csr_we_s) begin
        case (beat_csr_addr_r)
          12'h300: mstatus_r <= csr_wdata_s;
          12'h305: mtvec_r   <= csr_wdata_s;
          12'h341: mepc_r    <= csr_wdata_s;
          12'h342: mcause_r  <= csr_wdata_s;
          default: mstatus_r <= mstatus_r;
        endcase
      end
      if (beat_irq_r) begin
        mepc_r   <= beat_pc_r;
        mcause_r <= MCAUSE_ECALL;
      end
    end else begin
      mstatus_r <= mstatus_r;
    end
  end

  // Architectural PC and commit pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r     <= RESET_PC;
      npc_r    <= RESET_PC;
      commit_r <= 1'b0;
    end else if (state_r == WRITE) begin
      pc_r     <= next_pc_s;
      npc_r    <= next_pc_s;
      commit_r <= 1'b1;
    end else begin
      commit_r <= 1'b0;
    end
  end

  assign pc           = pc_r;
  assign npc          = npc_r;
  assign commit_valid = commit_r;

  assign rdata1 = (raddr1 == 4'd0) ? 32'd0 : gpr_r[raddr1];
  assign rdata2 = (raddr2 == 4'd0) ? 32'd0 : gpr_r[raddr2];

  // CSR read port; unmapped addresses read as zero
  always_comb begin
    csr_rdata = 32'd0;
    case (csr_raddr)
      12'h300: csr_rdata = mstatus_r;
      12'h305: csr_rdata = mtvec_r;
      12'h341: csr_rdata = mepc_r;
      12'h342: csr_rdata = mcause_r;
      default: csr_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24100006_wbu.sv
// Bench for the write-back stage: a transaction-level model checked every cycle,
// plus directed beats with hand-computed expectations.
module tb_ysyx_24100006_wbu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc_W = 32'd0, alu_result_W = 32'd0, sext_imm_W = 32'd0;
  logic [31:0] rs1_data_W = 32'd0, rdata_csr_W = 32'd0, Mem_rdata_extend = 32'd0;
  logic [3:0]  rd_addr_W = 4'd0;
  logic [11:0] csr_addr_W = 12'd0;
  logic        irq_W = 1'b0, mret_W = 1'b0, PCW_W = 1'b0;
  logic        Gpr_Write_W = 1'b0, Csr_Write_W = 1'b0;
  logic [2:0]  Gpr_Write_RD_W = 3'd0;
  logic [1:0]  Csr_Write_RD_W = 2'd0;
  logic [3:0]  raddr1 = 4'd0, raddr2 = 4'd0;
  logic [31:0] rdata1, rdata2, csr_rdata, pc, npc;
  logic [11:0] csr_raddr = 12'd0;
  logic        commit_valid;

  ysyx_24100006_wbu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc_W(pc_W), .alu_result_W(alu_result_W), .sext_imm_W(sext_imm_W),
    .rs1_data_W(rs1_data_W), .rdata_csr_W(rdata_csr_W), .Mem_rdata_extend(Mem_rdata_extend),
    .rd_addr_W(rd_addr_W), .csr_addr_W(csr_addr_W), .irq_W(irq_W), .mret_W(mret_W),
    .PCW_W(PCW_W), .Gpr_Write_W(Gpr_Write_W), .Gpr_Write_RD_W(Gpr_Write_RD_W),
    .Csr_Write_W(Csr_Write_W), .Csr_Write_RD_W(Csr_Write_RD_W),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .pc(pc),
    .commit_valid(commit_valid), .npc(npc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int commit_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [31:0] pcv, alu, imm, rs1, old, mem;
    logic [3:0]  rd;
    logic [11:0] caddr;
    logic        irq, mret, pcw, gwe, cwe;
    logic [2:0]  gsel;
    logic [1:0]  cop;
  } beat_t;

  logic [31:0] m_gpr [16];
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_pc, exp_npc;
  logic        exp_commit, exp_ready, model_valid = 1'b0;
  beat_t       pend;
  logic        pend_valid;

  function automatic logic [31:0] m_csr(input logic [11:0] a);
    if (a == 12'h300) return m_mstatus;
    if (a == 12'h305) return m_mtvec;
    if (a == 12'h341) return m_mepc;
    if (a == 12'h342) return m_mcause;
    return 32'd0;
  endfunction

  task automatic retire(input beat_t b);
    logic [31:0] nxt, val, wb;
    nxt = b.irq ? m_mtvec : b.mret ? m_mepc : b.pcw ? b.alu : b.pcv + 32'd4;
    wb  = (b.gsel == 3'd0) ? b.alu : (b.gsel == 3'd1) ? b.mem :
          (b.gsel == 3'd2) ? b.pcv + 32'd4 : (b.gsel == 3'd3) ? b.imm :
          (b.gsel == 3'd4) ? b.old : 32'd0;
    if (b.gwe && b.rd != 4'd0) m_gpr[b.rd] = wb;
    if (b.cwe && b.cop != 2'd3) begin
      val = (b.cop == 2'd0) ? b.rs1 : (b.cop == 2'd1) ? (b.old | b.rs1) : (b.old & ~b.rs1);
      if (b.caddr == 12'h300) m_mstatus = val;
      if (b.caddr == 12'h305) m_mtvec = val;
      if (b.caddr == 12'h341) m_mepc = val;
      if (b.caddr == 12'h342) m_mcause = val;
    end
    if (b.irq) begin
      m_mepc   = b.pcv;
      m_mcause = 32'd11;
    end
    m_pc    = nxt;
    exp_npc = nxt;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) m_gpr[i] = 32'd0;
        m_mstatus = 32'h1800; m_mtvec = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0;
        m_pc = 32'h8000_0000; exp_npc = 32'h8000_0000;
        exp_commit = 1'b0; pend_valid = 1'b0; model_valid = 1'b1;
      end else begin
        exp_commit = 1'b0;
        if (pend_valid) begin
          retire(pend);
          exp_commit = 1'b1;
          pend_valid = 1'b0;
        end else if (in_valid) begin
          pend = '{pc_W, alu_result_W, sext_imm_W, rs1_data_W, rdata_csr_W, Mem_rdata_extend,
                   rd_addr_W, csr_addr_W, irq_W, mret_W, PCW_W, Gpr_Write_W, Csr_Write_W,
                   Gpr_Write_RD_W, Csr_Write_RD_W};
          pend_valid = 1'b1;
        end
      end
      exp_ready = !pend_valid;
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (commit_valid === 1'b1) commit_cnt++;
      if (model_valid) begin
        check("cyc_in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        check("cyc_commit", {31'd0, commit_valid}, {31'd0, exp_commit});
        check("cyc_pc", pc, m_pc);
        if (exp_commit) check("cyc_npc", npc, exp_npc);
        check("cyc_rdata1", rdata1, m_gpr[raddr1]);
        check("cyc_rdata2", rdata2, m_gpr[raddr2]);
        check("cyc_csr", csr_rdata, m_csr(csr_raddr));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_beat(input logic [31:0] p, a, imm, r1, old, mem,
                          input logic [3:0] rd, input logic [11:0] ca,
                          input logic irq, mret, pcw, gwe, input logic [2:0] gsel,
                          input logic cwe, input logic [1:0] cop);
    pc_W = p; alu_result_W = a; sext_imm_W = imm; rs1_data_W = r1; rdata_csr_W = old;
    Mem_rdata_extend = mem; rd_addr_W = rd; csr_addr_W = ca; irq_W = irq; mret_W = mret;
    PCW_W = pcw; Gpr_Write_W = gwe; Gpr_Write_RD_W = gsel; Csr_Write_W = cwe;
    Csr_Write_RD_W = cop;
  endtask

  // Presents the prepared beat; returns at the negedge of the commit cycle.
  task automatic send();
    int guard = 0;
    @(posedge clk); #2;
    while (!exp_ready && guard < 8) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!exp_ready) check("idle_wait", {31'd0, exp_ready}, 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_no_early_commit", {31'd0, commit_valid}, 32'd0);
    @(negedge clk);
    check("lat_commit", {31'd0, commit_valid}, 32'd1);
  endtask

  int c0;

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    raddr1 = 4'd5; csr_raddr = 12'h300;
    @(negedge clk);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_commit", {31'd0, commit_valid}, 32'd0);
    check("rst_x5", rdata1, 32'd0);
    check("rst_mstatus", csr_rdata, 32'h1800);

    // ALU write-back
    set_beat(32'h8000_0000, 32'h1234, 32'd0, 32'd0, 32'd0, 32'd0, 4'd5, 12'd0,
             1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd3);
    send();
    check("alu_npc", npc, 32'h8000_0004);
    check("alu_x5", rdata1, 32'h1234);

    // x0 stays zero, jump redirects PC
    raddr1 = 4'd0;
    set_beat(32'h8000_0004, 32'h8000_0100, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 12'd0,
             1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 2'd3);
    send();
    check("jmp_x0", rdata1, 32'd0);
    check("jmp_pc", pc, 32'h8000_0100);

    // in_valid held for 4 cycles gives two commits
    @(posedge clk); #2;
    c0 = commit_cnt;
    set_beat(32'h8000_0100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 12'd0,
             1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd3);
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #2 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_commits", commit_cnt - c0, 32'd2);
    check("hold_pc", pc, 32'h8000_0104);

    // CSR set-bits with old value written to x3
    raddr2 = 4'd3; csr_raddr = 12'h300;
    set_beat(32'h8000_0104, 32'd0, 32'd0, 32'h8, 32'h1800, 32'd0, 4'd3, 12'h300,
             1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 2'd1);
    send();
    check("csrs_mstatus", csr_rdata, 32'h1808);
    check("csrs_x3", rdata2, 32'h1800);

    // CSR clear-bits, then plain write of mtvec, then an unmapped write
    set_beat(32'h8000_0108, 32'd0, 32'd0, 32'h8, 32'h1808, 32'd0, 4'd0, 12'h300,
             1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 2'd2);
    send();
    check("csrc_mstatus", csr_rdata, 32'h1800);
    csr_raddr = 12'h305;
    set_beat(32'h8000_010C, 32'd0, 32'd0, 32'h8000_0400, 32'd0, 32'd0, 4'd0, 12'h305,
             1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0);
    send();
    check("csrw_mtvec", csr_rdata, 32'h8000_0400);
    csr_raddr = 12'h7C0;
    set_beat(32'h8000_0110, 32'd0, 32'd0, 32'hFFFF, 32'd0, 32'd0, 4'd0, 12'h7C0,
             1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0);
    send();
    check("unmapped_read", csr_rdata, 32'd0);

    // Trap: same-beat mepc write is overridden; GPR write still happens
    csr_raddr = 12'h341; raddr1 = 4'd4;
    set_beat(32'h8000_0010, 32'h55, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 4'd4, 12'h341,
             1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 2'd0);
    send();
    check("trap_npc", npc, 32'h8000_0400);
    check("trap_mepc", csr_rdata, 32'h8000_0010);
    check("trap_x4", rdata1, 32'h55);
    @(posedge clk); #2 csr_raddr = 12'h342;
    @(negedge clk);
    check("trap_mcause", csr_rdata, 32'd11);

    // mret takes priority over a PC redirect
    set_beat(32'h8000_0400, 32'h1, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 12'd0,
             1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 2'd3);
    send();
    check("mret_npc", npc, 32'h8000_0010);
    check("mret_pc", pc, 32'h8000_0010);

    // pc+4 wraps to zero; also an out-of-range source select on x6 writes 0
    raddr1 = 4'd5; raddr2 = 4'd6;
    set_beat(32'hFFFF_FFFC, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd5, 12'd0,
             1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 2'd3);
    send();
    check("wrap_npc", npc, 32'd0);
    check("wrap_x5", rdata1, 32'd0);
    set_beat(32'h0, 32'h77, 32'h66, 32'd0, 32'h99, 32'h88, 4'd6, 12'd0,
             1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 2'd3);
    send();
    check("imm_x6", rdata2, 32'h66);
    set_beat(32'h4, 32'h77, 32'h66, 32'd0, 32'h99, 32'h88, 4'd6, 12'd0,
             1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 2'd3);
    send();
    check("sel7_x6", rdata2, 32'd0);

    // Reset asserted during WRITE discards the beat
    raddr1 = 4'd7;
    @(posedge clk); #2;
    set_beat(32'h8, 32'hDEAD, 32'd0, 32'd0, 32'd0, 32'd0, 4'd7, 12'd0,
             1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd3);
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_commit", {31'd0, commit_valid}, 32'd0);
    check("rstw_x7", rdata1, 32'd0);
    check("rstw_ready", {31'd0, in_ready}, 32'd1);
    check("rstw_pc", pc, 32'h8000_0000);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
